// File: rtl/vram_arbiter.sv
// Two-requester VRAM port arbiter: scanout (A, read-only, priority) and blitter (B, read/write).
// Optional starvation guard for B is compiled in with VRAM_ARB_STARVE_GUARD_EN.
module vram_arbiter #(
   parameter int unsigned STARVE_LIMIT = 7
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        vram_input_valid,
   input  logic        vram_data_out_valid,
   input  logic [7:0]  vram_data_out,
   output logic [15:0] vram_addr,
   output logic        vram_write_enable,
   output logic [7:0]  vram_data_in,
   input  logic        a_req,
   input  logic [15:0] a_addr,
   output logic        a_ack,
   output logic [7:0]  a_rdata,
   output logic        a_rvalid,
   input  logic        b_req,
   input  logic        b_we,
   input  logic [15:0] b_addr,
   input  logic [7:0]  b_wdata,
   output logic        b_ack,
   output logic [7:0]  b_rdata,
   output logic        b_rvalid,
   output logic        err
);

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
      $error("vram_arbiter: STARVE_LIMIT must be in 1..15");
   end

   // Handshake: a requester holds req (and its address/data) until it sees its ack;
   // ack is a one-cycle pulse in the slot it won, and the request may drop or change after.
   logic        slot;
   logic        force_b;
   logic        a_win;
   logic        b_win;
   logic [15:0] last_addr;
   logic        rd_pending;
   logic        rd_owner;   // 0 = A, 1 = B

   assign slot = rst_n && vram_input_valid;

`ifdef VRAM_ARB_STARVE_GUARD_EN
   logic [3:0] starve_cnt;

   assign force_b = (starve_cnt == 4'(STARVE_LIMIT));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         starve_cnt <= 4'd0;
      end else if (b_win) begin
         starve_cnt <= 4'd0;
      end else if (a_win && b_req) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end
`else
   assign force_b = 1'b0;
`endif

   assign a_win = slot && a_req && !(b_req && force_b);
   assign b_win = slot && b_req && (!a_req || force_b);

   always_comb begin
      vram_addr         = rst_n ? last_addr : 16'h0000;
      vram_write_enable = 1'b0;
      vram_data_in      = 8'h00;
      if (a_win) begin
         vram_addr = a_addr;
      end else if (b_win) begin
         vram_addr         = b_addr;
         vram_write_enable = b_we;
         vram_data_in      = b_we ? b_wdata : 8'h00;
      end
   end

   assign a_ack = a_win;
   assign b_ack = b_win;

   // Read data returns exactly one cycle after the slot; a missing strobe drops the read.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_addr  <= 16'h0000;
         rd_pending <= 1'b0;
         rd_owner   <= 1'b0;
         a_rdata    <= 8'h00;
         a_rvalid   <= 1'b0;
         b_rdata    <= 8'h00;
         b_rvalid   <= 1'b0;
         err        <= 1'b0;
      end else begin
         if (a_win || b_win) begin
            last_addr <= vram_addr;
         end
         rd_pending <= a_win || (b_win && !b_we);
         rd_owner   <= b_win;
         a_rvalid   <= rd_pending && !rd_owner && vram_data_out_valid;
         b_rvalid   <= rd_pending &&  rd_owner && vram_data_out_valid;
         if (rd_pending && vram_data_out_valid && !rd_owner) begin
            a_rdata <= vram_data_out;
         end
         if (rd_pending && vram_data_out_valid && rd_owner) begin
            b_rdata <= vram_data_out;
         end
         if (rd_pending && !vram_data_out_valid) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter; starvation expectations follow VRAM_ARB_STARVE_GUARD_EN.
module tb_vram_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        vram_input_valid;
   logic        vram_data_out_valid;
   logic [7:0]  vram_data_out;
   logic [15:0] vram_addr;
   logic        vram_write_enable;
   logic [7:0]  vram_data_in;
   logic        a_req;
   logic [15:0] a_addr;
   logic        a_ack;
   logic [7:0]  a_rdata;
   logic        a_rvalid;
   logic        b_req;
   logic        b_we;
   logic [15:0] b_addr;
   logic [7:0]  b_wdata;
   logic        b_ack;
   logic [7:0]  b_rdata;
   logic        b_rvalid;
   logic        err;

   int checks = 0;
   int errors = 0;

   vram_arbiter #(.STARVE_LIMIT(7)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .vram_input_valid    (vram_input_valid),
      .vram_data_out_valid (vram_data_out_valid),
      .vram_data_out       (vram_data_out),
      .vram_addr           (vram_addr),
      .vram_write_enable   (vram_write_enable),
      .vram_data_in        (vram_data_in),
      .a_req               (a_req),
      .a_addr              (a_addr),
      .a_ack               (a_ack),
      .a_rdata             (a_rdata),
      .a_rvalid            (a_rvalid),
      .b_req               (b_req),
      .b_we                (b_we),
      .b_addr              (b_addr),
      .b_wdata             (b_wdata),
      .b_ack               (b_ack),
      .b_rdata             (b_rdata),
      .b_rvalid            (b_rvalid),
      .err                 (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      logic exp_b;
      rst_n = 1'b0; vram_input_valid = 1'b0; vram_data_out_valid = 1'b0; vram_data_out = 8'h00;
      a_req = 1'b0; a_addr = 16'h0000; b_req = 1'b0; b_we = 1'b0; b_addr = 16'h0000; b_wdata = 8'h00;

      // reset: requests and slot present but ignored
      tick(); tick();
      vram_input_valid = 1'b1; a_req = 1'b1; a_addr = 16'hFFFF;
      #1;
      check("rst_a_ack", a_ack, 0);
      check("rst_addr", vram_addr, 16'h0000);
      check("rst_we", vram_write_enable, 0);
      tick();
      check("rst_a_rvalid", a_rvalid, 0);
      check("rst_a_rdata", a_rdata, 0);
      check("rst_b_rdata", b_rdata, 0);
      check("rst_err", err, 0);
      rst_n = 1'b1; a_req = 1'b0; vram_input_valid = 1'b0;
      tick();

      // A read 0x1234 returning 0x5A
      a_req = 1'b1; a_addr = 16'h1234; vram_input_valid = 1'b1;
      #1;
      check("a_rd_ack", a_ack, 1);
      check("a_rd_addr", vram_addr, 16'h1234);
      check("a_rd_we", vram_write_enable, 0);
      check("a_rd_b_ack", b_ack, 0);
      tick();
      a_req = 1'b0; vram_input_valid = 1'b0; vram_data_out_valid = 1'b1; vram_data_out = 8'h5A;
      #1;
      check("a_rd_n1_ack", a_ack, 0);
      check("a_rd_n1_hold_addr", vram_addr, 16'h1234);
      check("a_rd_n1_rvalid", a_rvalid, 0);
      tick();
      vram_data_out_valid = 1'b0; vram_data_out = 8'h00;
      #1;
      check("a_rd_n2_rvalid", a_rvalid, 1);
      check("a_rd_n2_rdata", a_rdata, 8'h5A);
      check("a_rd_n2_b_rvalid", b_rvalid, 0);
      check("a_rd_n2_b_rdata", b_rdata, 8'h00);
      tick();
      check("a_rd_n3_rvalid", a_rvalid, 0);
      check("a_rd_n3_rdata", a_rdata, 8'h5A);

      // B write offered in a non-slot cycle, then a slot
      b_req = 1'b1; b_we = 1'b1; b_addr = 16'h8001; b_wdata = 8'hC3;
      #1;
      check("b_wr_noslot_we", vram_write_enable, 0);
      check("b_wr_noslot_ack", b_ack, 0);
      tick();
      vram_input_valid = 1'b1;
      #1;
      check("b_wr_we", vram_write_enable, 1);
      check("b_wr_addr", vram_addr, 16'h8001);
      check("b_wr_data", vram_data_in, 8'hC3);
      check("b_wr_ack", b_ack, 1);
      tick();
      b_req = 1'b0; b_we = 1'b0; vram_input_valid = 1'b0;
      #1;
      check("b_wr_n1_ack", b_ack, 0);
      tick();
      check("b_wr_n2_rvalid", b_rvalid, 0);
      tick();
      check("b_wr_n3_rvalid", b_rvalid, 0);
      check("b_wr_err", err, 0);

      // back-to-back reads: A then B
      a_req = 1'b1; a_addr = 16'h0010; vram_input_valid = 1'b1;
      #1;
      check("bb_a_ack", a_ack, 1);
      tick();
      a_req = 1'b0; b_req = 1'b1; b_addr = 16'h0020;
      vram_data_out_valid = 1'b1; vram_data_out = 8'h11;
      #1;
      check("bb_b_ack", b_ack, 1);
      check("bb_b_addr", vram_addr, 16'h0020);
      tick();
      b_req = 1'b0; vram_input_valid = 1'b0; vram_data_out = 8'h22;
      #1;
      check("bb_a_rvalid", a_rvalid, 1);
      check("bb_a_rdata", a_rdata, 8'h11);
      check("bb_b_rvalid_early", b_rvalid, 0);
      tick();
      vram_data_out_valid = 1'b0; vram_data_out = 8'h00;
      #1;
      check("bb_b_rvalid", b_rvalid, 1);
      check("bb_b_rdata", b_rdata, 8'h22);
      check("bb_a_rvalid_late", a_rvalid, 0);
      check("bb_a_rdata_kept", a_rdata, 8'h11);
      check("bb_err", err, 0);
      tick();

      // request withdrawn before any slot
      a_req = 1'b1; a_addr = 16'h3333;
      #1;
      check("wd_noslot_ack", a_ack, 0);
      tick();
      a_req = 1'b0; vram_input_valid = 1'b1;
      #1;
      check("wd_idle_ack", a_ack, 0);
      check("wd_idle_we", vram_write_enable, 0);
      check("wd_idle_addr", vram_addr, 16'h0020);
      tick();
      vram_input_valid = 1'b0;
      tick();
      check("wd_rvalid", a_rvalid, 0);
      check("wd_err", err, 0);

      // both requesting for 20 slots; A reads always answered, B writes
      a_req = 1'b1; a_addr = 16'h1000; b_req = 1'b1; b_we = 1'b1; b_addr = 16'h9000; b_wdata = 8'hEE;
      vram_input_valid = 1'b1; vram_data_out_valid = 1'b1; vram_data_out = 8'h77;
      for (int s = 1; s <= 20; s++) begin
         #1;
`ifdef VRAM_ARB_STARVE_GUARD_EN
         exp_b = (s == 8) || (s == 16);
`else
         exp_b = 1'b0;
`endif
         check($sformatf("starve_b_ack_s%0d", s), b_ack, exp_b);
         check($sformatf("starve_a_ack_s%0d", s), a_ack, !exp_b);
         tick();
      end
      a_req = 1'b0; b_req = 1'b0; b_we = 1'b0; vram_input_valid = 1'b0;
      tick();
      vram_data_out_valid = 1'b0; vram_data_out = 8'h00;
      tick();
      check("starve_err", err, 0);

      // A read with no returned data
      a_req = 1'b1; a_addr = 16'h2222; vram_input_valid = 1'b1;
      #1;
      check("drop_ack", a_ack, 1);
      tick();
      a_req = 1'b0; vram_input_valid = 1'b0;
      tick();
      check("drop_rvalid", a_rvalid, 0);
      check("drop_err", err, 1);
      tick(); tick();
      check("drop_rvalid_later", a_rvalid, 0);
      check("drop_err_sticky", err, 1);
      rst_n = 1'b0;
      tick();
      check("drop_err_cleared", err, 0);
      rst_n = 1'b1;
      tick();

      // reset in the cycle after an A read slot
      a_req = 1'b1; a_addr = 16'h4444; vram_input_valid = 1'b1;
      #1;
      check("rstflight_ack", a_ack, 1);
      tick();
      rst_n = 1'b0; a_req = 1'b0; b_req = 1'b1; b_we = 1'b1; b_addr = 16'h5555; b_wdata = 8'h66;
      vram_data_out_valid = 1'b1; vram_data_out = 8'h99;
      #1;
      check("rstflight_b_ack", b_ack, 0);
      check("rstflight_we", vram_write_enable, 0);
      check("rstflight_addr", vram_addr, 16'h0000);
      check("rstflight_wdata", vram_data_in, 8'h00);
      tick();
      rst_n = 1'b1; b_req = 1'b0; b_we = 1'b0; vram_input_valid = 1'b0;
      vram_data_out_valid = 1'b0; vram_data_out = 8'h00;
      #1;
      check("rstflight_rvalid", a_rvalid, 0);
      check("rstflight_rdata", a_rdata, 8'h00);
      check("rstflight_err", err, 0);
      tick();
      check("rstflight_rvalid_after", a_rvalid, 0);
      check("rstflight_addr_after", vram_addr, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
